// File: rtl/pixel_mac_pkg.sv
// pixel_mac_pkg: shared sizes and FSM state type for the 10-row pixel MAC.
package pixel_mac_pkg;
   localparam int NUM_ROWS = 10;
   localparam int PIX_W    = 16;
   localparam int W_W      = 16;
   localparam int N_PIX    = 784;
   localparam int ACC_W    = 44;
   localparam int RD_LAT   = 1;
   localparam int IDX_W    = (N_PIX > 1) ? $clog2(N_PIX) : 1;
   localparam int LAT_W    = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
   localparam int PROD_W   = PIX_W + W_W + 1;
   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
endpackage

// File: rtl/mac_lane.sv
// mac_lane: unsigned pixel x signed weight multiply-accumulate with clear and enable.
module mac_lane
   import pixel_mac_pkg::*;
(
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    clr,
   input  logic                    en,
   input  logic [PIX_W-1:0]        pix,
   input  logic [W_W-1:0]          w,
   output logic signed [ACC_W-1:0] acc
);
   logic signed [PROD_W-1:0] prod;
   // zero-extend the pixel so the multiply stays signed without flipping large pixels negative
   assign prod = $signed({1'b0, pix}) * $signed(w);
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) acc <= '0;
      else if (clr) acc <= '0;
      else if (en) acc <= acc + ACC_W'(prod);
endmodule

// File: rtl/pixel_mac10.sv
// pixel_mac10: sweeps the pixel index over the SRAM and accumulates 10 signed dot products.
module pixel_mac10
   import pixel_mac_pkg::*;
(
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      start,
   output logic [IDX_W-1:0]          n_out,
   output logic                      rd_en,
   input  logic [NUM_ROWS*PIX_W-1:0] pix_in,
   input  logic [W_W-1:0]            weight_in,
   output logic                      busy,
   output logic                      done,
   output logic [NUM_ROWS*ACC_W-1:0] acc_out
);
   state_t            state;
   logic [RD_LAT-1:0] tag;
   logic [LAT_W-1:0]  dcnt;
   logic              clr;
   assign rd_en = state == RUN;
   assign busy  = state == RUN || state == DRAIN;
   assign done  = state == DONE;
   assign clr   = state == IDLE && start;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state <= IDLE;
         n_out <= '0;
         dcnt  <= '0;
         tag   <= '0;
      end else begin
         // tag is a shift register whose top bit marks data aligned with the current inputs
         tag <= RD_LAT'({tag, rd_en});
         case (state)
            IDLE:  if (start) state <= RUN;
            RUN:   if (n_out == IDX_W'(N_PIX - 1)) begin
                      state <= DRAIN;
                      n_out <= '0;
                      dcnt  <= '0;
                   end else n_out <= n_out + 1'b1;
            DRAIN: if (dcnt == LAT_W'(RD_LAT - 1)) state <= DONE;
                   else dcnt <= dcnt + 1'b1;
            default: state <= IDLE;
         endcase
      end
   for (genvar r = 0; r < NUM_ROWS; r++) begin : g_lane
      mac_lane u_lane (
         .clk   (clk),
         .rst_n (rst_n),
         .clr   (clr),
         .en    (tag[RD_LAT-1]),
         .pix   (pix_in[r*PIX_W +: PIX_W]),
         .w     (weight_in),
         .acc   (acc_out[r*ACC_W +: ACC_W])
      );
   end
endmodule

// File: tb/tb_pixel_mac10.sv
// tb_pixel_mac10: randomized scoreboard bench with an arithmetic dot-product reference.
module tb_pixel_mac10;
   import pixel_mac_pkg::*;
   logic                      clk = 0, rst_n = 0, start = 0;
   logic [IDX_W-1:0]          n_out;
   logic                      rd_en, busy, done;
   logic [NUM_ROWS*PIX_W-1:0] pix_in;
   logic [W_W-1:0]            weight_in;
   logic [NUM_ROWS*ACC_W-1:0] acc_out;
   int compared = 0, mismatched = 0, cyc = 0;
   int busy_cnt = 0, idx = 0;
   logic [PIX_W-1:0] pmem [NUM_ROWS][N_PIX];
   logic [W_W-1:0]   wmem [N_PIX];
   logic [NUM_ROWS*ACC_W-1:0] exp_q [$];
   int                        cyc_q [$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   pixel_mac10 dut (
      .clk(clk), .rst_n(rst_n), .start(start), .n_out(n_out), .rd_en(rd_en),
      .pix_in(pix_in), .weight_in(weight_in), .busy(busy), .done(done), .acc_out(acc_out)
   );

   // SRAM/weight store with one output register; garbage when no read is issued
   always @(posedge clk) begin
      for (int r = 0; r < NUM_ROWS; r++)
         pix_in[r*PIX_W +: PIX_W] <= rd_en ? pmem[r][n_out] : PIX_W'($urandom);
      weight_in <= rd_en ? wmem[n_out] : W_W'($urandom);
   end

   task automatic chk(input string name, input longint act, input longint req);
      compared++;
      if (act !== req) begin
         mismatched++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
      end
   endtask

   task automatic fill(input int mode);
      for (int n = 0; n < N_PIX; n++) begin
         wmem[n] = mode == 0 ? 16'd1 : mode == 1 ? 16'h8000 : mode == 2 ? W_W'(n) : W_W'($urandom);
         for (int r = 0; r < NUM_ROWS; r++)
            pmem[r][n] = mode == 0 ? 16'd1 : mode == 1 ? 16'hFFFF : mode == 2 ? PIX_W'(r + 1) : PIX_W'($urandom);
      end
   endtask

   // called at a negedge: push the reference result and pulse start for one cycle
   task automatic go();
      logic [NUM_ROWS*ACC_W-1:0] e;
      for (int r = 0; r < NUM_ROWS; r++) begin
         longint s = 0;
         for (int n = 0; n < N_PIX; n++)
            s += longint'(pmem[r][n]) * longint'($signed(wmem[n]));
         e[r*ACC_W +: ACC_W] = s[ACC_W-1:0];
      end
      exp_q.push_back(e);
      cyc_q.push_back(cyc + N_PIX + RD_LAT + 1);
      start = 1;
      @(negedge clk);
      start = 0;
   endtask

   task automatic wait_done();
      bit got = 0;
      for (int i = 0; i < 3000 && !got; i++) begin
         @(negedge clk);
         got = done;
      end
      chk("done_timeout", longint'(got), 1);
   endtask

   // monitor: checks index sequence, busy length and final sums against the scoreboard
   always @(negedge clk) begin
      if (!rst_n) begin
         exp_q.delete();
         cyc_q.delete();
         busy_cnt = 0;
         idx = 0;
      end else begin
         if (busy) busy_cnt++;
         if (rd_en) begin
            chk("n_out_seq", longint'(n_out), idx);
            idx++;
         end
         if (done) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_done", 1, 0);
            end else begin
               logic [NUM_ROWS*ACC_W-1:0] e;
               e = exp_q.pop_front();
               chk("done_cycle", cyc, cyc_q.pop_front());
               for (int r = 0; r < NUM_ROWS; r++)
                  chk($sformatf("lane%0d", r), longint'($signed(acc_out[r*ACC_W +: ACC_W])),
                      longint'($signed(e[r*ACC_W +: ACC_W])));
               chk("busy_cycles", busy_cnt, N_PIX + RD_LAT);
               chk("rd_en_cycles", idx, N_PIX);
               chk("busy_in_done", longint'(busy), 0);
            end
            busy_cnt = 0;
            idx = 0;
         end
      end
   end

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_busy", longint'(busy), 0);
      chk("rst_done", longint'(done), 0);
      chk("rst_rd_en", longint'(rd_en), 0);
      chk("rst_n_out", longint'(n_out), 0);
      chk("rst_acc_nonzero", longint'(acc_out != '0), 0);
      rst_n = 1;
      repeat (2) @(negedge clk);
      fill(0); go(); wait_done();
      chk("ones_lane0_const", longint'($signed(acc_out[0 +: ACC_W])), 784);
      repeat (2) @(negedge clk);
      fill(1); go(); wait_done();
      chk("extreme_lane9_const", longint'($signed(acc_out[9*ACC_W +: ACC_W])), -64'sd1683601489920);
      repeat (2) @(negedge clk);
      fill(2); go();
      @(negedge clk);
      start = 1;
      @(negedge clk);
      start = 0;
      wait_done();
      repeat (3) @(negedge clk);
      fill(3); go(); wait_done();
      @(negedge clk);
      fill(3); go(); wait_done();
      start = 1;
      @(negedge clk);
      start = 0;
      repeat (900) @(negedge clk);
      chk("start_in_done_ignored", longint'(busy), 0);
      fill(0); go();
      begin
         bit hit = 0;
         for (int i = 0; i < 1000 && !hit; i++) begin
            @(negedge clk);
            hit = rd_en && n_out == IDX_W'(300);
         end
         chk("reach_n300", longint'(hit), 1);
      end
      rst_n = 0;
      #1;
      chk("midrst_busy", longint'(busy), 0);
      chk("midrst_rd_en", longint'(rd_en), 0);
      chk("midrst_n_out", longint'(n_out), 0);
      chk("midrst_acc_nonzero", longint'(acc_out != '0), 0);
      @(negedge clk);
      rst_n = 1;
      @(negedge clk);
      fill(3); go(); wait_done();
      repeat (3) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
